// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external ALU between NUM_REQ requesters, one op in flight.
// Optional ALU_ARB_FAST_EN: operands go straight from the winning requester to the ALU, 1-cycle latency.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CORE_ALU_OP_WIDTH
`define CORE_ALU_OP_WIDTH 4
`endif
`ifndef CORE_ALU_ADD
`define CORE_ALU_ADD 0
`endif

module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*`CORE_ALU_OP_WIDTH-1:0] req_op,
    input  logic [NUM_REQ*`DATA_WIDTH-1:0]        req_opa,
    input  logic [NUM_REQ*`DATA_WIDTH-1:0]        req_opb,
    output logic [`DATA_WIDTH-1:0]                alu_oprand_0,
    output logic [`DATA_WIDTH-1:0]                alu_oprand_1,
    output logic [`CORE_ALU_OP_WIDTH-1:0]         alu_op,
    input  logic [`DATA_WIDTH-1:0]                alu_out,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [ID_W-1:0]                       rsp_id,
    output logic [`DATA_WIDTH-1:0]                rsp_data
);
    localparam int DW  = `DATA_WIDTH;
    localparam int OPW = `CORE_ALU_OP_WIDTH;
    localparam logic [OPW-1:0] OP_RST = OPW'(`CORE_ALU_ADD);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;

`ifdef ALU_ARB_FAST_EN
    localparam state_t ACC_ST = RESP;
`else
    localparam state_t ACC_ST = EXEC;
    logic [ID_W-1:0] id_q;
`endif

    logic [ID_W-1:0] rr_ptr, win_idx, ptr_nxt;
    logic            win_vld, grant_en, accept;
    logic [OPW-1:0]  op_q, win_op;
    logic [DW-1:0]   opa_q, opb_q, win_opa, win_opb;
    int              j;

    // Rotating search starting at rr_ptr; first valid requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_vld && req_valid[j]) begin
                win_vld = 1'b1;
                win_idx = ID_W'(j);
            end
        end
    end

    assign win_op  = req_op[win_idx*OPW +: OPW];
    assign win_opa = req_opa[win_idx*DW +: DW];
    assign win_opb = req_opb[win_idx*DW +: DW];
    assign ptr_nxt = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

`ifdef ALU_ARB_FAST_EN
    assign grant_en = (state == IDLE) || (state == RESP && rsp_ready);
`else
    assign grant_en = (state == IDLE);
`endif
    assign accept    = grant_en && win_vld;
    assign rsp_valid = (state == RESP);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = accept && (win_idx == ID_W'(i));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACC_ST;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = accept ? RESP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            op_q     <= OP_RST;
            opa_q    <= '0;
            opb_q    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
`ifndef ALU_ARB_FAST_EN
            id_q     <= '0;
`endif
        end else begin
            if (accept) begin
                op_q   <= win_op;
                opa_q  <= win_opa;
                opb_q  <= win_opb;
                rr_ptr <= ptr_nxt;
            end
`ifdef ALU_ARB_FAST_EN
            if (accept) begin
                rsp_data <= alu_out;
                rsp_id   <= win_idx;
            end
`else
            if (accept) id_q <= win_idx;
            if (state == EXEC) begin
                rsp_data <= alu_out;
                rsp_id   <= id_q;
            end
`endif
        end
    end

    // Fast build feeds the ALU from the winner while a grant is possible; otherwise from regs.
    always_comb begin
        alu_op       = op_q;
        alu_oprand_0 = opa_q;
        alu_oprand_1 = opb_q;
`ifdef ALU_ARB_FAST_EN
        if (grant_en) begin
            alu_op       = win_op;
            alu_oprand_0 = win_opa;
            alu_oprand_1 = win_opb;
        end
`endif
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (NUM_REQ=3): round-robin reference model, behavioural ALU,
// directed scenarios followed by randomized traffic and backpressure.
module tb_alu_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;
    localparam int DW      = 32;
    localparam int OPW     = 4;
`ifdef ALU_ARB_FAST_EN
    localparam int LAT = 1;
    localparam int GAP = 1;
`else
    localparam int LAT = 2;
    localparam int GAP = 3;
`endif

    typedef struct {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } req_t;
    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*OPW-1:0] req_op;
    logic [NUM_REQ*DW-1:0]  req_opa, req_opb;
    logic [DW-1:0]          alu_oprand_0, alu_oprand_1, alu_out, rsp_data;
    logic [OPW-1:0]         alu_op;
    logic                   rsp_valid, rsp_ready;
    logic [ID_W-1:0]        rsp_id;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    logic [NUM_REQ-1:0] hs = '0;
    req_t src_q [NUM_REQ][$];
    exp_t exp_q[$];
    exp_t log_q[$];
    int   model_ptr = 0, grant_cnt = 0, hs_cnt = 0;
    logic [NUM_REQ-1:0] last_grant = '0;
    bit   mon_en = 0, resp_new = 1;

    always #5 clk = ~clk;

    // Behavioural ALU: 0 ADD, 1 SUB, 2 SLT, 3 XOR, 4 SRA, 5 AND, 6 OR.
    function automatic logic [DW-1:0] alu_f(logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return {31'b0, $signed(a) < $signed(b)};
            4'd3: return a ^ b;
            4'd4: return $signed(a) >>> b[4:0];
            4'd5: return a & b;
            4'd6: return a | b;
            default: return '0;
        endcase
    endfunction
    assign alu_out = alu_f(alu_op, alu_oprand_0, alu_oprand_1);

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_opa(req_opa), .req_opb(req_opb),
        .alu_oprand_0(alu_oprand_0), .alu_oprand_1(alu_oprand_1), .alu_op(alu_op),
        .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic req_t mk(logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        req_t r;
        r.op = op; r.a = a; r.b = b;
        return r;
    endfunction

    function automatic int pick(logic [NUM_REQ-1:0] v, int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        hs  <= req_valid & req_ready;
    end

    // Requester drivers: present the queue head, hold it until the handshake edge.
    initial begin
        req_valid = '0; req_op = '0; req_opa = '0; req_opb = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rst_n) req_valid[i] = 1'b0;
                else begin
                    if (hs[i]) req_valid[i] = 1'b0;
                    if (!req_valid[i] && src_q[i].size() != 0) begin
                        req_t t;
                        t = src_q[i].pop_front();
                        req_valid[i] = 1'b1;
                        req_op[i*OPW +: OPW] = t.op;
                        req_opa[i*DW +: DW]  = t.a;
                        req_opb[i*DW +: DW]  = t.b;
                    end
                end
            end
        end
    end

    // Monitor: grant order against the round-robin model, responses against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (req_ready != '0) begin
                int w;
                logic [NUM_REQ-1:0] oh;
                w  = pick(req_valid, model_ptr);
                oh = '0;
                if (w >= 0) oh[w] = 1'b1;
                chk("grant", req_ready, oh);
                last_grant = req_ready;
                if (w >= 0) begin
                    exp_t e;
                    e.id   = w;
                    e.data = alu_f(req_op[w*OPW +: OPW], req_opa[w*DW +: DW], req_opb[w*DW +: DW]);
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                    model_ptr = (w + 1) % NUM_REQ;
                    grant_cnt++;
                end
            end
            if (rsp_valid && !rsp_ready) chk("bp_req_ready", req_ready, '0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_rsp: got id %0d data %0h expected no response", rsp_id, rsp_data);
                end else begin
                    if (resp_new) chk("latency", cyc - exp_q[0].cyc, LAT);
                    chk("rsp_id", rsp_id, exp_q[0].id);
                    chk("rsp_data", rsp_data, exp_q[0].data);
                    resp_new = 0;
                    if (rsp_ready) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        e.cyc = cyc;
                        log_q.push_back(e);
                        hs_cnt++;
                        resp_new = 1;
                    end
                end
            end
        end
    end

    function automatic bit busy();
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1;
        return (req_valid != '0) || (exp_q.size() != 0) || rsp_valid;
    endfunction

    task automatic drain(input int limit);
        int n = 0;
        while (busy() && n < limit) begin @(posedge clk); #3; n++; end
        if (n >= limit) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", limit);
        end
    endtask

    task automatic wait_grant(input int g0);
        int n = 0;
        while (grant_cnt == g0 && n < 50) begin @(posedge clk); n++; end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL grant_timeout: no grant within 50 cycles, expected one");
        end
    endtask

    task automatic pad_log(input int n);
        exp_t e;
        e.id = -1; e.data = '0; e.cyc = 0;
        while (log_q.size() < n) log_q.push_back(e);
    endtask

    initial begin
        int g0, h0, n;
        rst_n = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_opnd", {alu_oprand_0, alu_oprand_1}, 0);
        rst_n = 1'b1; mon_en = 1;
        @(posedge clk); #2 rsp_ready = 1'b1;

        // single ADD from req0
        log_q.delete();
        src_q[0].push_back(mk(4'd0, 32'd5, 32'd3));
        drain(100);
        chk("single_cnt", log_q.size(), 1);
        pad_log(1);
        chk("single_id", log_q[0].id, 0);
        chk("single_data", log_q[0].data, 32'h8);

        // only req2 valid, SRA; pointer wraps to 0
        log_q.delete();
        src_q[2].push_back(mk(4'd4, 32'h8000_0000, 32'd4));
        drain(100);
        chk("sra_cnt", log_q.size(), 1);
        pad_log(1);
        chk("sra_id", log_q[0].id, 2);
        chk("sra_data", log_q[0].data, 32'hF800_0000);

        // req0/req1 both held: alternate starting from 0
        log_q.delete();
        for (int k = 0; k < 2; k++) begin
            src_q[0].push_back(mk(4'd1, 32'd10, 32'd4));
            src_q[1].push_back(mk(4'd2, 32'hFFFF_FFFF, 32'd1));
        end
        drain(100);
        chk("rr_cnt", log_q.size(), 4);
        pad_log(4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_id", log_q[k].id, k % 2);
            chk("rr_data", log_q[k].data, (k % 2) ? 32'h1 : 32'h6);
            if (k > 0) chk("rr_gap", log_q[k].cyc - log_q[k-1].cyc, GAP);
        end

        // backpressure: hold RESP for 5 cycles with another request pending
        @(posedge clk); #2 rsp_ready = 1'b0;
        log_q.delete(); h0 = hs_cnt;
        src_q[1].push_back(mk(4'd3, 32'hA5A5_0000, 32'h0000_5A5A));
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #3; n++; end
        src_q[0].push_back(mk(4'd0, 32'd1, 32'd2));
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 1);
            chk("bp_data", rsp_data, 32'hA5A5_5A5A);
            chk("bp_ready", req_ready, 0);
        end
        @(posedge clk); #2 rsp_ready = 1'b1;
        drain(100);
        chk("bp_handshakes", hs_cnt - h0, 2);
        pad_log(2);
        chk("bp_first_id", log_q[0].id, 1);
        chk("bp_second_data", log_q[1].data, 32'h3);

        // reset in the middle of an operation
        g0 = grant_cnt;
        src_q[0].push_back(mk(4'd0, 32'd7, 32'd7));
        wait_grant(g0);
        #3;
        mon_en = 0; rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        chk("midrst_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1; model_ptr = 0; resp_new = 1; mon_en = 1;
        g0 = grant_cnt; h0 = hs_cnt;
        src_q[0].push_back(mk(4'd5, 32'h0000_F0F0, 32'h0000_FF00));
        src_q[1].push_back(mk(4'd6, 32'd1, 32'd2));
        wait_grant(g0);
        chk("postrst_first_grant", last_grant, 3'b001);
        drain(100);
        chk("postrst_handshakes", hs_cnt - h0, 2);

`ifdef ALU_ARB_FAST_EN
        log_q.delete();
        for (int k = 0; k < 4; k++) src_q[0].push_back(mk(4'd3, $urandom, $urandom));
        drain(100);
        chk("fast_cnt", log_q.size(), 4);
        pad_log(4);
        for (int k = 1; k < 4; k++) chk("fast_b2b", log_q[k].cyc - log_q[k-1].cyc, 1);
`endif

        // randomized traffic with random backpressure
        repeat (400) begin
            @(posedge clk); #2;
            for (int i = 0; i < NUM_REQ; i++)
                if (src_q[i].size() < 2 && $urandom_range(0, 2) == 0)
                    src_q[i].push_back(mk(4'($urandom_range(0, 6)), $urandom, $urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #2 rsp_ready = 1'b1;
        drain(500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
